// File: rtl/mul_booth_seq.sv
// Sequential radix-4 Booth multiplier: 8 digits per CALC pass into a carry-save accumulator, then one final add.
// Optional macro MUL_ZERO_SKIP_EN: a zero operand bypasses CALC/ADD and returns product 0 one edge after accept.
module mul_booth_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               a_signed,
    input  logic               b_signed,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned D      = WIDTH / 2 + 1;
    localparam int unsigned PASSES = (D + 7) / 8;
    localparam int unsigned CW     = $clog2(PASSES + 1);
    localparam int          PW     = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, ADD, DONE} state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  a_r, b_r;
    logic              as_r, bs_r;
    logic [PW-1:0]     sum_r, carry_r, sum_n, carry_n;
    logic [CW-1:0]     cnt;
    logic [PW-1:0]     a_se;
    logic [WIDTH+2:0]  bx;
    logic              accept;
    logic              last_pass;
    logic              zero_op;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && (state == IDLE) && !flush;
    assign last_pass = (cnt == CW'(PASSES - 1));
    assign zero_op   = (a == '0) || (b == '0);

    // Multiplicand sign/zero-extended straight to product width; multiplier
    // extended by two bits with an implicit zero below bit 0 for digit 0.
    assign a_se = {{(PW - WIDTH){as_r & a_r[WIDTH-1]}}, a_r};
    assign bx   = {{2{bs_r & b_r[WIDTH-1]}}, b_r, 1'b0};

    function automatic logic [PW-1:0] booth_pp(input logic [PW-1:0] m, input logic [2:0] g);
        logic [PW-1:0] r;
        case (g)
            3'b001, 3'b010: r = m;
            3'b011:         r = m << 1;
            3'b100:         r = -(m << 1);
            3'b101, 3'b110: r = -m;
            default:        r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        logic [PW-1:0] s, c, pp, t;
        logic [2:0]    grp;
        int unsigned   idx;
        s   = sum_r;
        c   = carry_r;
        pp  = '0;
        t   = '0;
        grp = '0;
        idx = 0;
        for (int unsigned j = 0; j < 8; j++) begin
            idx = 8 * 32'(cnt) + j;
            pp  = '0;
            if (idx < D) begin
                grp = 3'(bx >> (2 * idx));
                pp  = booth_pp(a_se, grp) << (2 * idx);
            end
            t = s ^ c ^ pp;
            c = ((s & c) | (s & pp) | (c & pp)) << 1;
            s = t;
        end
        sum_n   = s;
        carry_n = c;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
`ifdef MUL_ZERO_SKIP_EN
                    state_n = zero_op ? DONE : CALC;
`else
                    state_n = CALC;
`endif
                end
            end
            CALC:    if (last_pass) state_n = ADD;
            ADD:     state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            as_r    <= 1'b0;
            bs_r    <= 1'b0;
            sum_r   <= '0;
            carry_r <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            a_r     <= a;
            b_r     <= b;
            as_r    <= a_signed;
            bs_r    <= b_signed;
            sum_r   <= '0;
            carry_r <= '0;
            cnt     <= '0;
`ifdef MUL_ZERO_SKIP_EN
            if (zero_op) product <= '0;
`endif
        end else if (!flush) begin
            if (state == CALC) begin
                sum_r   <= sum_n;
                carry_r <= carry_n;
                cnt     <= cnt + 1'b1;
            end else if (state == ADD) begin
                product <= sum_r + carry_r;
            end
        end
    end

endmodule

// File: doc/mul_booth_seq.md
MUL_BOOTH_SEQ -- requirements
Module: mul_booth_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width; even, >= 8.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operand pair offered.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: a  input  WIDTH  multiplicand.
REQ-007 SHALL have port: b  input  WIDTH  multiplier.
REQ-008 SHALL have port: a_signed  input  1  treat a as two's complement.
REQ-009 SHALL have port: b_signed  input  1  treat b as two's complement.
REQ-010 SHALL have port: flush  input  1  abort any in-flight or held result.
REQ-011 SHALL have port: out_valid  output  1  product available.
REQ-012 SHALL have port: out_ready  input  1  consumer accepts product.
REQ-013 SHALL have port: product  output  2*WIDTH  full-width product.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, ADD, DONE.
REQ-015 SHALL assert in_ready only in IDLE; out_valid only in DONE.
REQ-016 SHALL, on in_valid&&in_ready, register a, b, sign flags; clear sum/carry accumulators and pass counter; IDLE->CALC.
REQ-017 SHALL extend each operand to WIDTH+2 bits (sign-extend if signed, else zero-extend), producing D=WIDTH/2+1 radix-4 Booth digits (-2..+2) of b.
REQ-018 SHALL, in CALC, each cycle generate up to 8 Booth partial products (digits 8k..8k+7, pass k), each shifted 2*digit-index, sign-extended to 2*WIDTH, and compress them with running sum and carry through a carry-save tree into new sum/carry; unused slots feed zero.
REQ-019 SHALL run PASSES=ceil(D/8) CALC cycles (3 for WIDTH=32), then CALC->ADD.
REQ-020 SHALL, in ADD, compute product = (sum + carry) mod 2^(2*WIDTH) with a single carry-propagate adder; ADD->DONE; product register written on this edge.
REQ-021 SHALL assert out_valid exactly PASSES+1 rising edges after the accepting edge (4 for WIDTH=32) when out_ready/flush are not involved.
REQ-022 SHALL hold product and out_valid stable in DONE until out_ready; on out_valid&&out_ready DONE->IDLE, in_ready high next cycle (no same-cycle re-accept).
REQ-023 SHALL, on flush in any state, go to IDLE next edge, discard in-flight operation, deassert out_valid; flush has priority over accept and out_ready in the same cycle.
REQ-024 SHALL ignore a, b, sign flags outside the accepting cycle; input changes mid-operation do not affect the result.
REQ-025 SHALL produce the exact mathematical product for all four signedness combinations, including most-negative operands.

Reset
REQ-026 SHALL, with rst high at a rising edge, enter IDLE; in_ready=1, out_valid=0, product=0, accumulators and pass counter cleared.
REQ-027 SHALL give rst priority over flush, accept and out_ready; reset mid-CALC or in DONE discards the operation.

Configuration
REQ-028 SHALL, with macro MUL_ZERO_SKIP_EN defined, on accepting an operand pair where a==0 or b==0, go IDLE->DONE directly with product=0; out_valid one edge after the accepting edge.
REQ-029 SHALL, without MUL_ZERO_SKIP_EN, treat zero operands like any other (full PASSES+1 latency, product 0).

Verification
REQ-030 SHALL cover: unsigned a=7, b=6 -> product=0x000000000000002A, out_valid 4 edges after accept.
REQ-031 SHALL cover: unsigned a=b=0xFFFFFFFF -> 0xFFFFFFFE00000001; signed same operands -> 0x0000000000000001.
REQ-032 SHALL cover: signed a=b=0x80000000 -> 0x4000000000000000; a signed 0x80000000, b unsigned 0xFFFFFFFF -> 0x8000000080000000.
REQ-033 SHALL cover: out_ready held low 10 cycles in DONE -> product/out_valid stable, in_ready=0; out_ready high -> IDLE, in_ready=1 next cycle.
REQ-034 SHALL cover: flush in 2nd CALC cycle, then new pair a=3, b=5 -> only product 0x0F emitted; rst asserted in DONE -> out_valid=0, product=0 next edge.
REQ-035 SHALL cover: a=0, b=0x12345678 -> product=0, out_valid after 1 edge with MUL_ZERO_SKIP_EN, after 4 edges without.
